// File: rtl/alu_arbiter.sv
// Purpose : two-requester round-robin front end that issues one operation at a time to a shared ALU.
// Latency : 4 cycles minimum from request sampled to done (IDLE, ISSUE, WAIT with alu_rdy, DONE).
// Backpressure: requests wait in IDLE while an operation is in flight; WAIT holds until alu_rdy.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req*/op*/a*/b*              requester operation requests, opcodes and operands
//   gnt*, done*                 ownership from grant through done; one-cycle completion pulse
//   res_acc1/res_acc2/res_flags captured ALU results, held until the next capture
//   busy, err                   not-IDLE indicator; sticky timeout flag
//   alu_*                       handshake, opcode and operands to/from the shared ALU
//
// Optional feature: define ALU_ARB_TIMEOUT_EN to give WAIT a TIMEOUT_CYCLES limit.
// On expiry the operation completes with zeroed results and err latches high.

module alu_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [5:0]  op0,
    input  logic [5:0]  op1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] res_acc1,
    output logic [15:0] res_acc2,
    output logic [3:0]  res_flags,
    output logic        busy,
    output logic        err,
    output logic        alu_bgn,
    output logic [5:0]  alu_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_acc1,
    input  logic [15:0] alu_acc2,
    input  logic [3:0]  alu_flags,
    input  logic        alu_rdy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        ptr_q;                 // requester that wins a tie
    logic        sel_q, sel_d;          // requester currently being served
    logic        gnt0_q, gnt1_q;
    logic [5:0]  op_q;
    logic [15:0] a_q, b_q;
    logic [15:0] acc1_q, acc2_q;
    logic [3:0]  flags_q;
    logic        timeout;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;

    // cnt_q counts completed WAIT cycles; expiry fires on the last permitted one.
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and arbitration
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // Tie goes to the pointer; a lone request wins outright.
                    sel_d   = (req0 && req1) ? ptr_q : req1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (alu_rdy || timeout) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Grant, operand latch, result capture and pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= 1'b0;
            sel_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc1_q  <= '0;
            acc2_q  <= '0;
            flags_q <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        sel_q  <= sel_d;
                        gnt0_q <= ~sel_d;
                        gnt1_q <= sel_d;
                        op_q   <= sel_d ? op1 : op0;
                        a_q    <= sel_d ? a1  : a0;
                        b_q    <= sel_d ? b1  : b0;
                    end
                end
                S_ISSUE: begin
`ifdef ALU_ARB_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                end
                S_WAIT: begin
                    if (alu_rdy) begin
                        acc1_q  <= alu_acc1;
                        acc2_q  <= alu_acc2;
                        flags_q <= alu_flags;
                    end else if (timeout) begin
                        acc1_q  <= '0;
                        acc2_q  <= '0;
                        flags_q <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
                        err_q   <= 1'b1;
`endif
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    cnt_q <= cnt_q + 1'b1;
`endif
                end
                S_DONE: begin
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                    ptr_q  <= ~sel_q;
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        gnt0       = gnt0_q;
        gnt1       = gnt1_q;
        done0      = (state_q == S_DONE) && !sel_q;
        done1      = (state_q == S_DONE) &&  sel_q;
        busy       = (state_q != S_IDLE);
        alu_bgn    = (state_q == S_ISSUE);
        alu_opcode = (state_q == S_IDLE) ? 6'd0 : op_q;
        alu_a      = a_q;
        alu_b      = b_q;
        res_acc1   = acc1_q;
        res_acc2   = acc2_q;
        res_flags  = flags_q;
`ifdef ALU_ARB_TIMEOUT_EN
        err        = err_q;
`else
        err        = 1'b0;
`endif
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [5:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] res_acc1, res_acc2;
    logic [3:0]  res_flags;
    logic        busy, err, alu_bgn;
    logic [5:0]  alu_opcode;
    logic [15:0] alu_a, alu_b;
    logic [15:0] alu_acc1 = '0, alu_acc2 = '0;
    logic [3:0]  alu_flags = '0;
    logic        alu_rdy_m = 1'b0;
    logic        force_rdy;
    logic        alu_rdy;

    int errors = 0;
    int checks = 0;
    int alu_lat;
    int alu_cd = 0;
    int bgn_cnt = 0;
    logic g1_seen = 1'b0;
    int n;

    typedef struct {
        logic        who;
        logic [15:0] acc1;
        logic [15:0] acc2;
        logic [3:0]  flags;
    } exp_t;
    exp_t sb[$];

    assign alu_rdy = alu_rdy_m | force_rdy;

    always #5 clk = ~clk;

    alu_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res_acc1(res_acc1), .res_acc2(res_acc2), .res_flags(res_flags),
        .busy(busy), .err(err),
        .alu_bgn(alu_bgn), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_acc1(alu_acc1), .alu_acc2(alu_acc2), .alu_flags(alu_flags), .alu_rdy(alu_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic who, input logic [15:0] acc1,
                        input logic [15:0] acc2, input logic [3:0] flags);
        exp_t e;
        e.who = who; e.acc1 = acc1; e.acc2 = acc2; e.flags = flags;
        sb.push_back(e);
    endtask

    // Advance until the chosen done pulse is visible; n = cycles advanced.
    task automatic wait_done(input logic who, input string tag, output int cnt);
        logic seen;
        seen = 1'b0;
        cnt  = 0;
        while (!seen && cnt < 60) begin
            tick();
            cnt++;
            if ((who ? done1 : done0) === 1'b1) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, seen, 1'b1);
    endtask

    // ALU model: result appears alu_lat cycles after the start pulse (0 = never).
    always @(negedge clk) begin
        logic [16:0] t;
        logic        v;
        alu_rdy_m = 1'b0;
        if (!rst_n) begin
            alu_cd = 0;
        end else begin
            if (alu_cd > 0) begin
                alu_cd--;
                if (alu_cd == 0) alu_rdy_m = 1'b1;
            end
            if (alu_bgn) begin
                v = 1'b0;
                case (alu_opcode)
                    6'd1: begin
                        t = {1'b0, alu_a} + {1'b0, alu_b};
                        v = (alu_a[15] == alu_b[15]) && (t[15] != alu_a[15]);
                    end
                    6'd2: begin
                        t = {1'b0, alu_a} - {1'b0, alu_b};
                        v = (alu_a[15] != alu_b[15]) && (t[15] != alu_a[15]);
                    end
                    6'd3:    t = {1'b0, alu_a << alu_b[3:0]};
                    default: t = '0;
                endcase
                alu_acc1  = t[15:0];
                alu_acc2  = alu_a ^ alu_b;
                alu_flags = {t[15:0] == 16'd0, t[15], t[16], v};
                alu_cd    = alu_lat;
            end
            if (force_rdy) begin
                alu_acc1  = 16'hDEAD;
                alu_acc2  = 16'hBEEF;
                alu_flags = 4'hF;
            end
        end
    end

    // Completion scoreboard and per-cycle exclusivity
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (alu_bgn) bgn_cnt++;
            if (gnt1) g1_seen = 1'b1;
            chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
            chk("done_exclusive", {31'd0, done0 & done1}, 32'd0);
            if (done0 || done1) begin
                chk("done_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("done_who", done1, e.who);
                    chk("res_acc1", res_acc1, e.acc1);
                    chk("res_acc2", res_acc2, e.acc2);
                    chk("res_flags", res_flags, e.flags);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        alu_lat = 1; force_rdy = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_done", {done1, done0}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_bgn", alu_bgn, 0);
        chk("rst_opcode", alu_opcode, 0);
        chk("rst_alu_ab", {alu_a, alu_b}, 0);
        chk("rst_res", {res_acc1, res_acc2}, 0);
        chk("rst_flags", res_flags, 0);
        rst_n = 1'b1;
        tick();

        // Single ADD, operands changed after grant must not leak in
        bgn_cnt = 0; g1_seen = 1'b0;
        op0 = 6'd1; a0 = 16'd5; b0 = 16'd3; req0 = 1'b1;
        push(1'b0, 16'd8, 16'd6, 4'b0000);
        tick();
        chk("t1_gnt0", gnt0, 1);
        op0 = 6'd2; a0 = 16'h1234; b0 = 16'h0007;
        wait_done(1'b0, "t1", n);
        chk("t1_latency", n + 1, 3);
        req0 = 1'b0;
        chk("t1_bgn_once", bgn_cnt, 1);
        chk("t1_gnt1_never", g1_seen, 0);
        tick();
        chk("t1_gnt_release", gnt0, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_res_hold", res_acc1, 16'd8);

        // Both requesting out of reset: 0 first, then 1 after one IDLE
        rst_n = 1'b0;
        op0 = 6'd2; a0 = 16'd10; b0 = 16'd4;
        op1 = 6'd3; a1 = 16'd1;  b1 = 16'd4;
        req0 = 1'b1; req1 = 1'b1;
        push(1'b0, 16'd6,  16'h000E, 4'b0000);
        push(1'b1, 16'd16, 16'h0005, 4'b0000);
        tick();
        rst_n = 1'b1;
        wait_done(1'b0, "t2a", n);
        chk("t2a_latency", n, 3);
        req0 = 1'b0;
        wait_done(1'b1, "t2b", n);
        chk("t2b_gap", n, 4);
        req1 = 1'b0;
        tick();

        // req0 held, req1 pulses: grants 0,1,0
        op0 = 6'd1; a0 = 16'd2; b0 = 16'd2; req0 = 1'b1;
        push(1'b0, 16'd4, 16'd0, 4'b0000);
        wait_done(1'b0, "t3a", n);
        chk("t3a_latency", n, 3);
        op1 = 6'd2; a1 = 16'd7; b1 = 16'd9; req1 = 1'b1;
        push(1'b1, 16'hFFFE, 16'h000E, 4'b0110);
        push(1'b0, 16'd4, 16'd0, 4'b0000);
        wait_done(1'b1, "t3b", n);
        chk("t3b_gap", n, 4);
        req1 = 1'b0;
        wait_done(1'b0, "t3c", n);
        chk("t3c_gap", n, 4);
        req0 = 1'b0;
        tick();

        // Requester drops req mid-operation, slower ALU
        alu_lat = 3;
        op1 = 6'd1; a1 = 16'hFFFF; b1 = 16'd1; req1 = 1'b1;
        push(1'b1, 16'd0, 16'hFFFE, 4'b1010);
        tick();
        chk("t4_gnt1", gnt1, 1);
        chk("t4_bgn", alu_bgn, 1);
        chk("t4_issue_op", alu_opcode, 6'd1);
        chk("t4_issue_a", alu_a, 16'hFFFF);
        req1 = 1'b0; a1 = 16'd0;
        tick();
        chk("t4_bgn_low", alu_bgn, 0);
        chk("t4_wait_op", alu_opcode, 6'd1);
        chk("t4_wait_b", alu_b, 16'd1);
        chk("t4_wait_busy", busy, 1);
        wait_done(1'b1, "t4", n);
        chk("t4_latency", n, 3);
        tick();
        chk("t4_idle_nop", alu_opcode, 0);
        chk("t4_gnt1_release", gnt1, 0);

        // alu_rdy outside WAIT is ignored
        force_rdy = 1'b1;
        repeat (3) tick();
        chk("t5_spur_busy", busy, 0);
        chk("t5_spur_flags", res_flags, 4'b1010);
        chk("t5_spur_acc2", res_acc2, 16'hFFFE);
        force_rdy = 1'b0;
        tick();

        // Reset during WAIT aborts without done
        alu_lat = 0;
        op0 = 6'd1; a0 = 16'd1; b0 = 16'd1; req0 = 1'b1;
        tick();
        tick();
        chk("t6_wait_busy", busy, 1);
        chk("t6_wait_gnt0", gnt0, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_abort_gnt0", gnt0, 0);
        chk("t6_abort_busy", busy, 0);
        chk("t6_abort_flags", res_flags, 0);
        tick();
        tick();
        alu_lat = 1;
        push(1'b0, 16'd2, 16'd0, 4'b0000);
        rst_n = 1'b1;
        wait_done(1'b0, "t6", n);
        chk("t6_latency", n, 3);
        req0 = 1'b0;
        tick();

        // ALU never ready
        alu_lat = 0;
        op1 = 6'd1; a1 = 16'd3; b1 = 16'd4; req1 = 1'b1;
`ifdef ALU_ARB_TIMEOUT_EN
        push(1'b1, 16'd0, 16'd0, 4'b0000);
        wait_done(1'b1, "t7", n);
        chk("t7_timeout_latency", n, 18);
        chk("t7_err", err, 1);
        req1 = 1'b0;
        tick();
        chk("t7_err_sticky", err, 1);
        chk("t7_idle", busy, 0);
`else
        repeat (40) tick();
        chk("t7_busy_held", busy, 1);
        chk("t7_err_zero", err, 0);
        chk("t7_gnt_held", gnt1, 1);
        req1 = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
`endif
        tick();
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have this parameter: TIMEOUT_CYCLES, 16, WAIT-state cycle limit, used only when ALU_ARB_TIMEOUT_EN is defined.
REQ-002 The block SHALL have these ports:
  - clk  in  1  rising-edge clock.
  - rst_n  in  1  asynchronous active-low reset.
  - req0, req1  in  1 each  requester 0/1 operation request; requester holds it until its done pulse.
  - op0, op1  in  6 each  requester opcode (NOP=0, ADD=1, SUB=2, SHL=3).
  - a0, b0, a1, b1  in  16 each  requester operands.
  - gnt0, gnt1  out  1 each  requester owns the ALU, from grant through done.
  - done0, done1  out  1 each  one-cycle pulse; the result is valid this cycle.
  - res_acc1, res_acc2  out  16 each  captured ALU results.
  - res_flags  out  4  captured {zero, negative, carry, overflow}.
  - busy  out  1  high in every state except IDLE.
  - err  out  1  timeout flag; constant 0 when the macro is off.
  - alu_bgn  out  1  start pulse to the ALU.
  - alu_opcode  out  6  opcode to the ALU.
  - alu_a, alu_b  out  16 each  operands to the ALU.
  - alu_acc1, alu_acc2  in  16 each  ALU results.
  - alu_flags  in  4  ALU {zero, negative, carry, overflow}.
  - alu_rdy  in  1  ALU result ready.

Function
REQ-003 The block SHALL use a 4-state FSM: IDLE, ISSUE, WAIT, DONE, one transition per clk edge.
REQ-004 In IDLE with any request sampled high, the block SHALL grant one requester, latch its opcode and operands into internal registers, assert its gnt on the next edge, and enter ISSUE.
REQ-005 Arbitration SHALL be round-robin: with both requests high, the requester indicated by the 1-bit priority pointer wins; after each DONE the pointer SHALL point to the requester that was not just served.
REQ-006 With a single request high, that requester SHALL win regardless of the pointer, and the pointer SHALL still update per REQ-005.
REQ-007 In ISSUE, alu_bgn SHALL be high for exactly one cycle, with alu_opcode/alu_a/alu_b driven from the latched registers; the FSM then enters WAIT.
REQ-008 alu_opcode/alu_a/alu_b SHALL stay stable from ISSUE through DONE; in IDLE, alu_opcode SHALL be NOP (0).
REQ-009 In WAIT, when alu_rdy is sampled high, the block SHALL capture alu_acc1, alu_acc2 and alu_flags into the res_* registers and enter DONE.
REQ-010 alu_rdy SHALL be ignored in any state other than WAIT.
REQ-011 In DONE, the granted requester's done SHALL pulse for one cycle; its gnt SHALL deassert on the following edge, and the FSM returns to IDLE.
REQ-012 Minimum latency from req sampled to done SHALL be 4 cycles (IDLE, ISSUE, WAIT with alu_rdy high, DONE).
REQ-013 Back-to-back operations SHALL cost one IDLE cycle between a DONE and the next grant.
REQ-014 res_* outputs SHALL hold their values until the next capture.
REQ-015 If the granted requester drops req mid-operation, the operation SHALL still complete and done SHALL still pulse.
REQ-016 Latched operands SHALL NOT change if the requester changes its inputs after the grant.
REQ-017 gnt0 and gnt1 SHALL never be high in the same cycle, nor done0 and done1.

Reset
REQ-018 rst_n low SHALL asynchronously force state to IDLE, the pointer to requester 0, and all outputs and registers to 0 (gnt, done, busy, err, alu_bgn, alu_opcode, alu_a, alu_b, res_*).
REQ-019 Reset asserted mid-operation SHALL abort it with no done pulse; the first request after deassertion follows REQ-004.

Configuration
REQ-020 The macro ALU_ARB_TIMEOUT_EN SHALL control the WAIT-state timeout:
  - Defined: a counter clears on entry to WAIT. If TIMEOUT_CYCLES cycles pass in WAIT without alu_rdy, the FSM enters DONE with res_acc1=res_acc2=0 and res_flags=0, and sets err high. err stays sticky until reset.
  - Undefined: WAIT waits indefinitely, there is no counter, and err is tied to 0.

Verification
REQ-021 req0 with op0=ADD, a0=5, b0=3, ALU model returns rdy after 1 cycle -> alu_bgn pulses once, done0 on the 4th cycle, res_acc1=8, gnt1 stays 0.
REQ-022 req0 and req1 both high from reset, op0=SUB 10-4, op1=SHL 1<<4 -> requester 0 is served first (res_acc1=6), then requester 1 (res_acc1=16), with one IDLE cycle between.
REQ-023 req0 held continuously while req1 pulses -> grants alternate 0,1,0; no requester is granted twice in a row while the other is waiting.
REQ-024 rst_n pulled low during WAIT -> immediately gnt0=0, busy=0, no done; a fresh request after release gives correct results.
REQ-025 With ALU_ARB_TIMEOUT_EN defined, alu_rdy held 0 -> done pulses after TIMEOUT_CYCLES=16 WAIT cycles with err=1 and res_acc1=0; without the macro, busy stays high indefinitely and err stays 0.
